// File: rtl/dmem_responder.sv
// dmem_responder
// ---------------------------------------------------------------------------
// Memory side of the core's load/store interface. Accepts one load or store
// at a time, waits LATENCY cycles, then returns read data (loads) or a write
// acknowledgement (stores), flagging misaligned or out-of-range addresses.
// Storage is a word-organised array addressed by byte addresses.
//
// Parameters
//   ADDR_WIDTH  word-index bits, depth = 2**ADDR_WIDTH words (legal 1..29)
//   LATENCY     cycles from request accept to response (legal 1..15)
//
// Optional feature (compile-time macro DMEM_BYTE_EN_EN)
//   Adds input req_be[3:0]; stores write only enabled byte lanes, and a store
//   with no lane enabled is reported as an error without writing.
//
// Ports
//   clk         clock, rising edge
//   rst         synchronous active-high reset
//   req_valid   request present
//   req_ready   responder can accept a request (registered)
//   req_write   1 = store, 0 = load
//   req_addr    byte address
//   req_wdata   store data
//   req_be      store byte-lane enables (DMEM_BYTE_EN_EN only)
//   resp_valid  response present (registered)
//   resp_ready  requester accepts the response
//   resp_rdata  load data; 0 for stores and errors (registered)
//   resp_err    request was misaligned or out of range (registered)
//   dbg_state   current FSM state (0 = IDLE, 1 = WAIT, 2 = RESP)
//
// Handshake: a request transfers on a rising edge where req_valid and
// req_ready are both 1; a response transfers on a rising edge where
// resp_valid and resp_ready are both 1. Once resp_valid is raised, it and
// resp_rdata/resp_err stay unchanged until that transfer edge.
// ---------------------------------------------------------------------------
module dmem_responder #(
    parameter int ADDR_WIDTH = 10,
    parameter int LATENCY    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
`ifdef DMEM_BYTE_EN_EN
    input  logic [3:0]  req_be,
`endif
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [1:0]  dbg_state
);

    // Elaboration-time parameter checks
    if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
        $error("dmem_responder: LATENCY must be in 1..15");
    end
    if (ADDR_WIDTH < 1 || ADDR_WIDTH > 29) begin : g_bad_addr_width
        $error("dmem_responder: ADDR_WIDTH must be in 1..29");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int         DEPTH    = 1 << ADDR_WIDTH;
    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    logic [31:0] mem [DEPTH];

    state_t                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic                  req_ready_d, resp_valid_d, resp_err_d;
    logic [31:0]           resp_rdata_d;
    logic                  accept;
    logic                  commit;
    logic                  req_err;

    // Request captured at accept
    logic                  wr_q;
    logic [ADDR_WIDTH-1:0] idx_q;
    logic [31:0]           wdata_q;
    logic                  err_q;
    logic [3:0]            be_q;

    assign dbg_state = state_q;

    // Error decode on the incoming request: low address bits must be zero and
    // nothing may be set above the word-index field.
`ifdef DMEM_BYTE_EN_EN
    assign req_err = (req_addr[1:0] != 2'b00)
                  || (req_addr[31:ADDR_WIDTH+2] != '0)
                  || (req_write && (req_be == 4'b0000));
`else
    assign req_err = (req_addr[1:0] != 2'b00)
                  || (req_addr[31:ADDR_WIDTH+2] != '0);
`endif

    // Next-state and output logic
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        req_ready_d  = req_ready;
        resp_valid_d = resp_valid;
        resp_rdata_d = resp_rdata;
        resp_err_d   = resp_err;
        accept       = 1'b0;
        commit       = 1'b0;
        case (state_q)
            IDLE: begin
                // Re-raises ready on the first edge after reset.
                req_ready_d = 1'b1;
                if (req_valid && req_ready) begin
                    accept      = 1'b1;
                    req_ready_d = 1'b0;
                    cnt_d       = CNT_INIT;
                    state_d     = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    // Access happens on the edge that leaves WAIT.
                    commit       = wr_q && !err_q;
                    resp_rdata_d = (wr_q || err_q) ? 32'd0 : mem[idx_q];
                    resp_err_d   = err_q;
                    resp_valid_d = 1'b1;
                    state_d      = RESP;
                end
            end
            RESP: begin
                if (resp_ready) begin
                    resp_valid_d = 1'b0;
                    resp_err_d   = 1'b0;
                    req_ready_d  = 1'b1;
                    state_d      = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= 4'd0;
            req_ready  <= 1'b0;
            resp_valid <= 1'b0;
            resp_rdata <= 32'd0;
            resp_err   <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            req_ready  <= req_ready_d;
            resp_valid <= resp_valid_d;
            resp_rdata <= resp_rdata_d;
            resp_err   <= resp_err_d;
        end
    end

    // Request capture; only meaningful after an accept, so no reset needed.
    always_ff @(posedge clk) begin
        if (accept) begin
            wr_q    <= req_write;
            idx_q   <= req_addr[ADDR_WIDTH+1:2];
            wdata_q <= req_wdata;
            err_q   <= req_err;
        end
    end

`ifdef DMEM_BYTE_EN_EN
    always_ff @(posedge clk) begin
        if (accept) begin
            be_q <= req_be;
        end
    end
`else
    assign be_q = 4'hF;
`endif

    // Storage array, not reset. A reset on the commit edge discards the store.
    always_ff @(posedge clk) begin
        if (commit && !rst) begin
            for (int i = 0; i < 4; i++) begin
                if (be_q[i]) begin
                    mem[idx_q][8*i +: 8] <= wdata_q[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Testbench for dmem_responder: directed checks from the test plan plus
// randomized loads/stores/resets compared every cycle against a
// transaction-level model (memory as an associative array, response due
// at accept time + LATENCY).
module tb_dmem_responder;

  localparam int LAT_A = 2;
  localparam int LAT_B = 4;
  localparam int AW    = 10;
`ifdef DMEM_BYTE_EN_EN
  localparam bit BE_EN = 1'b1;
`else
  localparam bit BE_EN = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        req_valid = 1'b0, req_write = 1'b0, resp_ready = 1'b0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic [3:0]  req_be = 4'hF;
  logic        req_ready, resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic [1:0]  dbg_state;

  logic        b_rst = 1'b1;
  logic        b_req_valid = 1'b0, b_req_write = 1'b0, b_resp_ready = 1'b0;
  logic [31:0] b_req_addr = '0, b_req_wdata = '0;
  logic        b_req_ready, b_resp_valid, b_resp_err;
  logic [31:0] b_resp_rdata;
  logic [1:0]  b_state;

  dmem_responder #(.ADDR_WIDTH(AW), .LATENCY(LAT_A)) u_dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
`ifdef DMEM_BYTE_EN_EN
    .req_be(req_be),
`endif
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err), .dbg_state(dbg_state)
  );

  dmem_responder #(.ADDR_WIDTH(AW), .LATENCY(LAT_B)) u_dut_b (
    .clk(clk), .rst(b_rst),
    .req_valid(b_req_valid), .req_ready(b_req_ready), .req_write(b_req_write),
    .req_addr(b_req_addr), .req_wdata(b_req_wdata),
`ifdef DMEM_BYTE_EN_EN
    .req_be(4'hF),
`endif
    .resp_valid(b_resp_valid), .resp_ready(b_resp_ready),
    .resp_rdata(b_resp_rdata), .resp_err(b_resp_err), .dbg_state(b_state)
  );

  // ---------------- scoreboard counters ----------------
  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual=%h expected=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic timeout_fail(input string nm);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: timed out waiting for DUT t=%0t", nm, $time);
  endtask

  // ---------------- reference model (instance A) ----------------
  logic [31:0] mm [int];
  int          cyc = 0;
  int          due = 0;
  bit          m_busy = 1'b0;
  logic        m_ready = 1'b0, m_valid = 1'b0, m_err = 1'b0;
  logic [31:0] m_rdata = '0;
  bit          m_known = 1'b1;
  bit          l_w;
  logic [31:0] l_a, l_d, wword;
  logic [3:0]  l_be, be_eff;
  int          key;

  function automatic bit addr_bad(input logic [31:0] a);
    return ((a % 4) != 0) || (a >= 32'(4 << AW));
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_ready = 1'b0; m_valid = 1'b0; m_busy = 1'b0;
      m_err = 1'b0; m_rdata = '0; m_known = 1'b1;
    end else if (m_valid) begin
      if (resp_ready) begin
        m_valid = 1'b0; m_err = 1'b0; m_ready = 1'b1;
      end
    end else if (m_busy) begin
      if (cyc == due) begin
        be_eff  = BE_EN ? l_be : 4'hF;
        m_err   = addr_bad(l_a) || (l_w && be_eff == 4'h0);
        m_rdata = '0;
        m_known = 1'b1;
        key     = int'(l_a >> 2);
        if (!m_err && l_w) begin
          wword = mm.exists(key) ? mm[key] : 32'd0;
          for (int i = 0; i < 4; i++)
            if (be_eff[i]) wword[8*i +: 8] = l_d[8*i +: 8];
          mm[key] = wword;
        end else if (!m_err) begin
          if (mm.exists(key)) m_rdata = mm[key];
          else m_known = 1'b0;
        end
        m_busy  = 1'b0;
        m_valid = 1'b1;
      end
    end else if (m_ready) begin
      if (req_valid) begin
        l_w = req_write; l_a = req_addr; l_d = req_wdata; l_be = req_be;
        due = cyc + LAT_A;
        m_ready = 1'b0;
        m_busy  = 1'b1;
      end
    end else begin
      m_ready = 1'b1;
    end
    cyc++;
  end

  // Compare process: outputs checked every cycle, data when a response is up.
  always @(negedge clk) begin
    check("req_ready", 32'(req_ready), 32'(m_ready));
    check("resp_valid", 32'(resp_valid), 32'(m_valid));
    if (m_valid) begin
      check("resp_err", 32'(resp_err), 32'(m_err));
      if (m_known) check("resp_rdata", resp_rdata, m_rdata);
    end
  end

  // ---------------- driver tasks (instance A) ----------------
  task automatic wait_accept(output bit acc);
    acc = 1'b0;
    for (int i = 0; i < 50 && !acc; i++) begin
      @(negedge clk);
      acc = req_ready;
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
  endtask

  task automatic do_req(input bit w, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] be, input int bp,
                        output logic [31:0] rd, output logic er, output int lat);
    bit acc;
    bit got;
    rd = '0; er = 1'b0; lat = 0; got = 1'b0;
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d; req_be = be;
    resp_ready = 1'b0;
    wait_accept(acc);
    if (!acc) begin
      timeout_fail("accept");
      return;
    end
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      if (resp_valid) got = 1'b1;
      else begin
        @(posedge clk); #1;
        lat++;
      end
    end
    if (!got) begin
      timeout_fail("response");
      return;
    end
    rd = resp_rdata;
    er = resp_err;
    // Backpressure: offer junk requests that must be ignored.
    for (int i = 0; i < bp; i++) begin
      @(posedge clk); #1;
      req_valid = 1'b1;
      req_write = 1'($urandom_range(0, 1));
      req_addr  = 32'($urandom_range(0, 15)) << 2;
      req_wdata = $urandom;
    end
    resp_ready = 1'b1;
    req_valid  = 1'b0;
    @(posedge clk); #1;
    resp_ready = 1'b0;
  endtask

  task automatic reset_mid(input bit w, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] be);
    bit acc;
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d; req_be = be;
    resp_ready = 1'b0;
    wait_accept(acc);
    if (!acc) begin
      timeout_fail("accept_rst");
      return;
    end
    repeat ($urandom_range(0, LAT_A + 1)) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // ---------------- driver task (instance B) ----------------
  task automatic b_accept(output bit acc);
    acc = 1'b0;
    for (int i = 0; i < 50 && !acc; i++) begin
      @(negedge clk);
      acc = b_req_ready;
      @(posedge clk); #1;
    end
    b_req_valid = 1'b0;
  endtask

  task automatic b_req(input bit w, input logic [31:0] a, input logic [31:0] d,
                       output logic [31:0] rd, output logic er);
    bit acc;
    bit got;
    rd = '0; er = 1'b0; got = 1'b0;
    b_req_valid = 1'b1; b_req_write = w; b_req_addr = a; b_req_wdata = d;
    b_accept(acc);
    if (!acc) begin
      timeout_fail("b_accept");
      return;
    end
    b_resp_ready = 1'b1;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      if (b_resp_valid) begin
        got = 1'b1;
        rd  = b_resp_rdata;
        er  = b_resp_err;
      end else begin
        @(posedge clk); #1;
      end
    end
    if (!got) timeout_fail("b_response");
    @(posedge clk); #1;
    b_resp_ready = 1'b0;
  endtask

  // ---------------- main sequence ----------------
  logic [31:0] rd, wd, addr;
  logic        er;
  int          lat;
  bit          w, acc;
  logic [3:0]  be;

  initial begin
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("rst_req_ready", 32'(req_ready), 32'd0);
      check("rst_resp_valid", 32'(resp_valid), 32'd0);
    end
    check("rst_state", 32'(dbg_state), 32'd0);
    rst = 1'b0;
    b_rst = 1'b0;
    @(posedge clk); #1;
    check("ready_after_rst", 32'(req_ready), 32'd1);
    check("b_ready_after_rst", 32'(b_req_ready), 32'd1);

    // Store then load
    do_req(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0, rd, er, lat);
    check("st_latency", 32'(lat), 32'd2);
    check("st_err", 32'(er), 32'd0);
    check("st_rdata", rd, 32'd0);
    do_req(1'b0, 32'h10, 32'd0, 4'hF, 0, rd, er, lat);
    check("ld_latency", 32'(lat), 32'd2);
    check("ld_rdata", rd, 32'hDEADBEEF);

    // Backpressure on a load response
    do_req(1'b0, 32'h10, 32'd0, 4'hF, 5, rd, er, lat);
    check("bp_rdata", rd, 32'hDEADBEEF);
    check("bp_idle_after", 32'(req_ready), 32'd1);

    // Errors
    do_req(1'b1, 32'h12, 32'h55555555, 4'hF, 0, rd, er, lat);
    check("misal_err", 32'(er), 32'd1);
    check("misal_rdata", rd, 32'd0);
    do_req(1'b0, 32'h10, 32'd0, 4'hF, 0, rd, er, lat);
    check("after_misal", rd, 32'hDEADBEEF);
    do_req(1'b0, 32'h1000, 32'd0, 4'hF, 0, rd, er, lat);
    check("oor_err", 32'(er), 32'd1);
    check("oor_rdata", rd, 32'd0);

`ifdef DMEM_BYTE_EN_EN
    do_req(1'b1, 32'h30, 32'hAABBCCDD, 4'hF, 0, rd, er, lat);
    do_req(1'b1, 32'h30, 32'h11223344, 4'b0101, 0, rd, er, lat);
    check("be_st_err", 32'(er), 32'd0);
    do_req(1'b0, 32'h30, 32'd0, 4'hF, 0, rd, er, lat);
    check("be_merge", rd, 32'hAA22CC44);
    do_req(1'b1, 32'h30, 32'h99999999, 4'b0000, 0, rd, er, lat);
    check("be_zero_err", 32'(er), 32'd1);
    do_req(1'b0, 32'h30, 32'd0, 4'hF, 0, rd, er, lat);
    check("be_zero_keep", rd, 32'hAA22CC44);
`endif

    // Give every word used by random traffic a known value.
    for (int i = 0; i < 16; i++)
      do_req(1'b1, 32'(i * 4), $urandom, 4'hF, 0, rd, er, lat);

    // Randomized traffic
    for (int n = 0; n < 300; n++) begin
      w  = 1'($urandom_range(0, 1));
      wd = $urandom;
      be = BE_EN ? 4'($urandom_range(0, 15)) : 4'hF;
      case ($urandom_range(0, 9))
        7:       addr = (32'($urandom_range(0, 15)) << 2) + 32'($urandom_range(1, 3));
        8:       addr = (32'($urandom_range(1, 1048575)) << 12) + (32'($urandom_range(0, 15)) << 2);
        default: addr = 32'($urandom_range(0, 15)) << 2;
      endcase
      if ($urandom_range(0, 9) == 0) reset_mid(w, addr, wd, be);
      else do_req(w, addr, wd, be, $urandom_range(0, 3), rd, er, lat);
    end

    // Reset mid-WAIT on the LATENCY=4 instance
    b_req(1'b1, 32'h20, 32'hCAFEF00D, rd, er);
    check("b_pre_store_err", 32'(er), 32'd0);
    b_req_valid = 1'b1; b_req_write = 1'b1; b_req_addr = 32'h20; b_req_wdata = 32'h12345678;
    b_accept(acc);
    if (!acc) timeout_fail("b_accept_rst");
    b_resp_ready = 1'b1;
    @(posedge clk); #1;
    b_rst = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    b_rst = 1'b0;
    check("b_state_after_rst", 32'(b_state), 32'd0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("b_no_resp", 32'(b_resp_valid), 32'd0);
    end
    b_resp_ready = 1'b0;
    @(posedge clk); #1;
    b_req(1'b0, 32'h20, 32'd0, rd, er);
    check("b_prestore_val", rd, 32'hCAFEF00D);
    check("b_load_err", 32'(er), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
